// File: rtl/cvec_result_writer_if.sv
// Bundle of job-control, input-vector handshake and result-memory write signals
// for the cvec result writer. master = upstream/controller side, slave = writer.
interface cvec_result_writer_if #(
  parameter int element_width = 64,
  parameter int no_of_units   = 8,
  parameter int addr_width    = 16
);
  logic                                 start;
  logic [31:0]                          total;
  logic [addr_width-1:0]                base_addr;
  logic [element_width*no_of_units-1:0] in_data;
  logic                                 in_valid;
  logic                                 in_ready;
  logic                                 mem_we;
  logic [addr_width-1:0]                mem_addr;
  logic [element_width-1:0]             mem_wdata;
  logic                                 busy;
  logic                                 finish;
  logic                                 overrun;
  logic [31:0]                          vec_count;

  modport master (
    output start, total, base_addr, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, finish, overrun, vec_count
  );

  modport slave (
    input  start, total, base_addr, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, finish, overrun, vec_count
  );
endinterface

// File: rtl/cvec_result_writer.sv
// Serialises packed complex result vectors into the result memory, one element
// per cycle, through a 2-entry ping-pong buffer, tracking the per-job quota.
module cvec_result_writer #(
  parameter int element_width = 64,
  parameter int no_of_units   = 8,
  parameter int addr_width    = 16
) (
  input logic                 clk,
  input logic                 reset,
  cvec_result_writer_if.slave bus
);

  localparam int                lane_w    = (no_of_units > 1) ? $clog2(no_of_units) : 1;
  localparam logic [lane_w-1:0] last_lane = lane_w'(no_of_units - 1);
  localparam logic [31:0]       units32   = 32'(no_of_units);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [31:0]              nvec_q;
  logic [31:0]              quota_q;
  logic [31:0]              vec_count_q;
  logic [31:0]              wr_idx_q;
  logic [addr_width-1:0]    base_q;
  logic [element_width-1:0] buf_q [2][no_of_units];
  logic                     wr_ptr_q;
  logic                     rd_ptr_q;
  logic [1:0]               occ_q;
  logic [lane_w-1:0]        lane_q;
  logic                     mem_we_q;
  logic [addr_width-1:0]    mem_addr_q;
  logic [element_width-1:0] mem_wdata_q;
  logic                     overrun_q;

  logic        launch;
  logic [31:0] launch_nvec;
  logic        quota_met;
  logic        in_ready;
  logic        accept;
  logic        drain;
  logic        free_entry;

  // A start is only honoured outside RUN; the remainder of total/no_of_units is dropped.
  assign launch      = bus.start && (state_q != RUN);
  assign launch_nvec = bus.total / units32;
  assign quota_met   = (vec_count_q == nvec_q);
  assign in_ready    = (state_q == RUN) && (occ_q < 2'd2) && !quota_met;
  assign accept      = bus.in_valid && in_ready;
  assign drain       = (state_q == RUN) && (occ_q != 2'd0);
  assign free_entry  = drain && (lane_q == last_lane);

  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (bus.start) state_d = (launch_nvec == 32'd0) ? DONE : RUN;
      RUN:        if (wr_idx_q == quota_q) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nvec_q      <= '0;
      quota_q     <= '0;
      vec_count_q <= '0;
      wr_idx_q    <= '0;
      base_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= '0;
      lane_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      overrun_q   <= 1'b0;
    end else if (launch) begin
      nvec_q      <= launch_nvec;
      quota_q     <= launch_nvec * units32;
      base_q      <= bus.base_addr;
      vec_count_q <= '0;
      wr_idx_q    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= '0;
      lane_q      <= '0;
      mem_we_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      mem_we_q <= drain;
      if (drain) begin
        mem_addr_q  <= base_q + wr_idx_q[addr_width-1:0];
        mem_wdata_q <= buf_q[rd_ptr_q][lane_q];
        wr_idx_q    <= wr_idx_q + 32'd1;
        lane_q      <= free_entry ? '0 : lane_q + lane_w'(1);
        if (free_entry) rd_ptr_q <= ~rd_ptr_q;
      end
      if (accept) begin
        wr_ptr_q    <= ~wr_ptr_q;
        vec_count_q <= vec_count_q + 32'd1;
      end
      // Accept and free in the same cycle leave the occupancy unchanged.
      unique case ({accept, free_entry})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
      if (bus.in_valid && (state_q != IDLE) && quota_met) overrun_q <= 1'b1;
    end
  end

  // NOTE: buffer storage is not reset; occ_q alone decides which entries hold live data.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < no_of_units; k++) begin
        buf_q[wr_ptr_q][k] <= bus.in_data[k*element_width +: element_width];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.finish    = (state_q == DONE);
  assign bus.overrun   = overrun_q;
  assign bus.vec_count = vec_count_q;

endmodule

// File: tb/tb_cvec_result_writer.sv
// Directed bench for cvec_result_writer: basic job, backpressure, quota edge
// cases, overrun, address wrap and asynchronous reset mid-job.
module tb_cvec_result_writer;

  localparam int ew = 64;
  localparam int nu = 8;
  localparam int aw = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cvec_result_writer_if #(.element_width(ew), .no_of_units(nu), .addr_width(aw)) bus ();

  cvec_result_writer #(.element_width(ew), .no_of_units(nu), .addr_width(aw)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int bad_we = 0;

  logic [aw-1:0] wa_q[$];
  logic [ew-1:0] wd_q[$];
  int            wc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write log, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wa_q.push_back(bus.mem_addr);
      wd_q.push_back(bus.mem_wdata);
      wc_q.push_back(cyc);
      if (bus.busy !== 1'b1) bad_we++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ew-1:0] elem(input int v, input int k);
    logic [31:0] re;
    re = 32'h5000_0000 | 32'(v * 256 + k);
    return {re, ~re};
  endfunction

  function automatic logic [ew*nu-1:0] make_vec(input int v);
    logic [ew*nu-1:0] r;
    for (int k = 0; k < nu; k++) r[k*ew +: ew] = elem(v, k);
    return r;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic launch(input logic [31:0] tot, input logic [aw-1:0] base);
    bus.start     = 1'b1;
    bus.total     = tot;
    bus.base_addr = base;
    step();
    bus.start = 1'b0;
  endtask

  // Presents vector v until accepted; reports the accepting edge and stall cycles.
  task automatic push(input int v, output int acc_edge, output int stalls);
    bus.in_data  = make_vec(v);
    bus.in_valid = 1'b1;
    acc_edge     = -1;
    stalls       = 0;
    for (int i = 0; i < 64; i++) begin
      if (bus.in_ready === 1'b1) begin
        acc_edge = cyc + 1;
        step();
        break;
      end
      stalls++;
      step();
    end
    check($sformatf("push_accept_v%0d", v), 64'(acc_edge >= 0), 64'd1);
  endtask

  task automatic wait_finish(output int fcyc);
    fcyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.finish === 1'b1) begin
        fcyc = cyc;
        break;
      end
      step();
    end
    check("finish_seen", 64'(fcyc >= 0), 64'd1);
  endtask

  task automatic check_writes(input string tag, input logic [aw-1:0] base, input int v0, input int n);
    logic [aw-1:0] ea;
    check({tag, "_count"}, 64'(wa_q.size()), 64'(n));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      ea = base + aw'(i);
      check($sformatf("%s_addr%0d", tag, i), 64'(wa_q[i]), 64'(ea));
      check($sformatf("%s_data%0d", tag, i), wd_q[i], elem(v0 + i / nu, i % nu));
    end
    if (wc_q.size() > 0)
      check({tag, "_contiguous"}, 64'(wc_q[wc_q.size()-1] - wc_q[0]), 64'(wc_q.size() - 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
    check({tag, "_mem_we"},    64'(bus.mem_we),    64'd0);
    check({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata,      64'd0);
    check({tag, "_busy"},      64'(bus.busy),      64'd0);
    check({tag, "_finish"},    64'(bus.finish),    64'd0);
    check({tag, "_overrun"},   64'(bus.overrun),   64'd0);
    check({tag, "_vec_count"}, 64'(bus.vec_count), 64'd0);
  endtask

  initial begin
    int a0, a1, fc, n;
    int st[6];

    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.total     = '0;
    bus.base_addr = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;

    // Reset held for three cycles.
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b1;
    step();

    // Basic job: two vectors into 0x0100..0x010F.
    clear_log();
    launch(32'd16, 16'h0100);
    check("basic_busy", 64'(bus.busy), 64'd1);
    push(0, a0, st[0]);
    push(1, a1, st[1]);
    bus.in_valid = 1'b0;
    wait_finish(fc);
    check_writes("basic", 16'h0100, 0, 16);
    if (wc_q.size() > 0) begin
      check("basic_first_latency", 64'(wc_q[0]), 64'(a0 + 1));
      check("basic_finish_cycle", 64'(fc), 64'(wc_q[wc_q.size()-1] + 1));
    end
    check("basic_vec_count", 64'(bus.vec_count), 64'd2);
    check("basic_busy_done", 64'(bus.busy), 64'd0);
    check("basic_ready_done", 64'(bus.in_ready), 64'd0);

    // Backpressure: four vectors offered back to back, 32 writes with no gap.
    clear_log();
    launch(32'd32, 16'h0200);
    for (int v = 2; v < 6; v++) push(v, a0, st[v]);
    bus.in_valid = 1'b0;
    wait_finish(fc);
    check("bp_stall_v2", 64'(st[2]), 64'd0);
    check("bp_stall_v3", 64'(st[3]), 64'd0);
    check("bp_stall_v4", 64'(st[4]), 64'd7);
    check("bp_stall_v5", 64'(st[5]), 64'd7);
    check_writes("bp", 16'h0200, 2, 32);
    check("bp_vec_count", 64'(bus.vec_count), 64'd4);

    // Remainder discarded: total=20 gives two vectors.
    clear_log();
    launch(32'd20, 16'h0300);
    push(6, a0, st[0]);
    push(7, a1, st[1]);
    check("rem_ready_quota", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    wait_finish(fc);
    check_writes("rem", 16'h0300, 6, 16);
    check("rem_vec_count", 64'(bus.vec_count), 64'd2);
    check("rem_overrun", 64'(bus.overrun), 64'd0);

    // Zero quota: finish one cycle after start, no writes.
    clear_log();
    launch(32'd5, 16'h0400);
    check("zero_finish", 64'(bus.finish), 64'd1);
    check("zero_busy", 64'(bus.busy), 64'd0);
    check("zero_ready", 64'(bus.in_ready), 64'd0);
    repeat (3) step();
    check("zero_writes", 64'(wa_q.size()), 64'd0);

    // Overrun: second vector offered after the one-vector quota is met.
    clear_log();
    launch(32'd8, 16'h0500);
    push(8, a0, st[0]);
    bus.in_data  = make_vec(9);
    bus.in_valid = 1'b1;
    check("ovr_ready", 64'(bus.in_ready), 64'd0);
    check("ovr_flag_before", 64'(bus.overrun), 64'd0);
    step();
    check("ovr_flag_set", 64'(bus.overrun), 64'd1);
    check("ovr_ready_held", 64'(bus.in_ready), 64'd0);
    repeat (2) step();
    bus.in_valid = 1'b0;
    wait_finish(fc);
    check_writes("ovr", 16'h0500, 8, 8);
    check("ovr_vec_count", 64'(bus.vec_count), 64'd1);
    check("ovr_sticky", 64'(bus.overrun), 64'd1);

    // Address wrap; the new start also clears overrun.
    clear_log();
    launch(32'd8, 16'hFFFC);
    check("wrap_overrun_cleared", 64'(bus.overrun), 64'd0);
    push(10, a0, st[0]);
    bus.in_valid = 1'b0;
    wait_finish(fc);
    check_writes("wrap", 16'hFFFC, 10, 8);

    // Asynchronous reset during the 5th write of a 16-element job.
    clear_log();
    launch(32'd16, 16'h0600);
    push(11, a0, st[0]);
    push(12, a1, st[1]);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40 && wa_q.size() < 5; i++) step();
    check("rst_write_index", 64'(wa_q.size()), 64'd5);
    check("rst_we_before", 64'(bus.mem_we), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    n = wa_q.size();
    repeat (3) step();
    check("rst_no_writes", 64'(wa_q.size()), 64'(n));
    reset = 1'b1;
    step();
    check("rst_idle_finish", 64'(bus.finish), 64'd0);

    // Fresh job after the abort.
    clear_log();
    launch(32'd16, 16'h0600);
    push(13, a0, st[0]);
    push(14, a1, st[1]);
    bus.in_valid = 1'b0;
    wait_finish(fc);
    check_writes("fresh", 16'h0600, 13, 16);
    check("fresh_vec_count", 64'(bus.vec_count), 64'd2);

    check("we_outside_run", 64'(bad_we), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
